// File: rtl/mdr_sequential_unit.sv
// Iterative unsigned multiply / divide / square-root unit, one iteration per clock.
// Optional feature macro: MDR_SQRT_EN enables Op=10 square root; otherwise Op=10 is invalid.
module mdr_sequential_unit #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Enable1,
  input  logic                       Enable2,
  input  logic [WORD_LENGTH-1:0]     Data_ch1,
  input  logic [WORD_LENGTH-1:0]     Data_ch2,
  input  logic [1:0]                 Op,
  input  logic                       flagStart,
  input  logic                       flush,
  output logic [2*WORD_LENGTH-1:0]   Result,
  output logic [WORD_LENGTH-1:0]     Remainder,
  output logic                       Error,
  output logic                       Busy,
  output logic                       Ready
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]   a_reg, b_reg;
  logic           fs_d;
  logic [1:0]     op_w;
  logic [2*W-1:0] x, nxt_x;      // multiplicand / dividend / radicand, shifted left
  logic [W-1:0]   y, nxt_y;      // multiplier (shifted right) / divisor
  logic [2*W-1:0] acc, nxt_acc;  // product accumulator
  logic [W-1:0]   r, nxt_r;      // partial remainder
  logic [W-1:0]   q, nxt_q;      // quotient / root
  logic [CW-1:0]  cnt, last;
  logic           start_p, is_div0, is_inv, finish;
  logic [W:0]     dtmp, ddiff;
`ifdef MDR_SQRT_EN
  logic [W+1:0]   stmp, strial, sdiff;
`endif

  always_comb begin
    start_p = flagStart & ~fs_d;
    is_div0 = (op_w == 2'b01) && (y == '0);
`ifdef MDR_SQRT_EN
    is_inv  = (op_w == 2'b11);
    last    = (op_w == 2'b10) ? CW'(W/2 - 1) : CW'(W - 1);
`else
    is_inv  = op_w[1];
    last    = CW'(W - 1);
`endif
    nxt_x   = x;
    nxt_y   = y;
    nxt_acc = acc;
    nxt_r   = r;
    nxt_q   = q;
    // restoring divide step: shift next dividend bit into the partial remainder
    dtmp    = {r, x[W-1]};
    ddiff   = dtmp - {1'b0, y};
`ifdef MDR_SQRT_EN
    // digit-by-digit root: bring down two radicand bits, trial subtract 4*root+1
    stmp    = {r, x[W-1:W-2]};
    strial  = {q, 2'b01};
    sdiff   = stmp - strial;
`endif
    case (op_w)
      2'b00: begin
        nxt_acc = acc + (y[0] ? x : '0);
        nxt_x   = x << 1;
        nxt_y   = y >> 1;
      end
      2'b01: begin
        nxt_x = x << 1;
        if (dtmp >= {1'b0, y}) begin
          nxt_r = ddiff[W-1:0];
          nxt_q = {q[W-2:0], 1'b1};
        end else begin
          nxt_r = dtmp[W-1:0];
          nxt_q = {q[W-2:0], 1'b0};
        end
      end
`ifdef MDR_SQRT_EN
      2'b10: begin
        nxt_x = x << 2;
        if (stmp >= strial) begin
          nxt_r = sdiff[W-1:0];
          nxt_q = {q[W-2:0], 1'b1};
        end else begin
          nxt_r = stmp[W-1:0];
          nxt_q = {q[W-2:0], 1'b0};
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (start_p && !flush) state_nxt = CALC;
      CALC: begin
        if (flush) state_nxt = IDLE;
        else if (is_div0 || is_inv || cnt == last) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy  = (state == CALC);
  assign Ready = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fs_d      <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_w      <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      Result    <= '0;
      Remainder <= '0;
      Error     <= 1'b0;
    end else begin
      state <= state_nxt;
      fs_d  <= flagStart;
      if (Enable1) a_reg <= Data_ch1;
      if (Enable2) b_reg <= Data_ch2;
      if (state == IDLE && start_p && !flush) begin
        x    <= {{W{1'b0}}, a_reg};
        y    <= b_reg;
        op_w <= Op;
        acc  <= '0;
        r    <= '0;
        q    <= '0;
        cnt  <= '0;
      end else if (state == CALC && !flush && !is_div0 && !is_inv) begin
        x   <= nxt_x;
        y   <= nxt_y;
        acc <= nxt_acc;
        r   <= nxt_r;
        q   <= nxt_q;
        cnt <= cnt + CW'(1);
      end
      if (finish) begin
        Error <= is_div0 | is_inv;
        if (is_div0) begin
          Result    <= '1;
          Remainder <= x[W-1:0];
        end else if (is_inv) begin
          Result    <= '0;
          Remainder <= '0;
        end else if (op_w == 2'b00) begin
          Result    <= nxt_acc;
          Remainder <= '0;
        end else begin
          Result    <= {{W{1'b0}}, nxt_q};
          Remainder <= nxt_r;
        end
      end
    end
  end
endmodule
